// File: rtl/startup_ctrl_pkg.sv
// startup_ctrl_pkg: sequencer state encoding and counter-width helper shared by the
// STARTUPE2 sequencer and its CCLK generator.
package startup_ctrl_pkg;

   typedef enum logic [2:0] {
      WAIT_EOS,
      RST_HOLD,
      DUMMY,
      RUN,
      PROG_PEND,
      PROG_ACK
   } state_t;

   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/startup_cclk_gen.sv
// startup_cclk_gen: USRCCLKO divider with enable gating, edge strobes and a saturating
// falling-edge counter; idles low whenever not running or forced low.
module startup_cclk_gen
   import startup_ctrl_pkg::*;
#(
   parameter int CCLK_HALF   = 4,
   parameter int DUMMY_CCLKS = 3
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          i_run,
   input  logic                          i_force_low,
   input  logic                          i_en,
   output logic                          o_cclk,
   output logic                          o_rise,
   output logic                          o_fall,
   output logic                          o_fall_nxt,
   output logic [cnt_w(DUMMY_CCLKS)-1:0] o_edge_cnt
);

   localparam int DW = cnt_w(CCLK_HALF);
   localparam int EW = cnt_w(DUMMY_CCLKS);
   localparam logic [DW-1:0] DIV_LAST = DW'(CCLK_HALF - 1);
   localparam logic [EW-1:0] EDGE_MAX = EW'(DUMMY_CCLKS);

   logic [DW-1:0] r_div;
   logic [EW-1:0] r_edge_cnt;
   logic          r_cclk;
   logic          r_rise;
   logic          r_fall;
   logic          w_active;
   logic          w_count;
   logic          w_toggle;

   assign w_active   = i_run && !i_force_low;
   // a high phase always runs to completion; a low phase only advances while enabled
   assign w_count    = w_active && (r_cclk || i_en);
   assign w_toggle   = w_count && (r_div == DIV_LAST);
   assign o_fall_nxt = w_toggle && r_cclk;

   always_ff @(posedge CLK) begin
      if (RST || !w_active) begin
         r_cclk     <= 1'b0;
         r_div      <= '0;
         r_rise     <= 1'b0;
         r_fall     <= 1'b0;
         r_edge_cnt <= '0;
      end else begin
         r_cclk <= r_cclk ^ w_toggle;
         r_div  <= (!w_count || w_toggle) ? '0 : r_div + 1'b1;
         r_rise <= w_toggle && !r_cclk;
         r_fall <= o_fall_nxt;
         if (o_fall_nxt && r_edge_cnt != EDGE_MAX)
            r_edge_cnt <= r_edge_cnt + 1'b1;
      end
   end

   assign o_cclk     = r_cclk;
   assign o_rise     = r_rise;
   assign o_fall     = r_fall;
   assign o_edge_cnt = r_edge_cnt;

endmodule

// File: rtl/startup_seq_ctrl.sv
// startup_seq_ctrl: STARTUPE2 post-configuration sequencer (EOS wait, reset hold, dummy CCLKs,
// CCLK handoff, PREQ/PACK). Define STARTUP_PACK_TIMEOUT_EN for the PROG_PEND auto-ack timeout.
module startup_seq_ctrl
   import startup_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int RST_HOLD_CYCLES = 16,
   parameter int CCLK_HALF       = 4,
   parameter int DUMMY_CCLKS     = 3
`ifdef STARTUP_PACK_TIMEOUT_EN
  ,parameter int PACK_TIMEOUT    = 1024
`endif
) (
   input  logic CLK,
   input  logic RST,
   input  logic eos_i,
   input  logic preq_i,
   output logic pack_o,
   output logic usrcclko_o,
   output logic usrcclkts_o,
   output logic usr_rst_o,
   output logic ready_o,
   input  logic cclk_en_i,
   output logic cclk_rise_o,
   output logic cclk_fall_o,
   output logic prog_pend_o,
   input  logic prog_ok_i
);

   localparam int HW = cnt_w(RST_HOLD_CYCLES);
   localparam int EW = cnt_w(DUMMY_CCLKS);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(DUMMY_CCLKS - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_eos_sync;
   logic [SYNC_STAGES-1:0] r_preq_sync;
   logic [HW-1:0]          r_hold;
   logic                   r_strb_ok;
   logic [EW-1:0]          w_edge_cnt;
   logic                   w_eos_s;
   logic                   w_preq_s;
   logic                   w_drive;
   logic                   w_svc;
   logic                   w_cclk;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_fall_nxt;
   logic                   w_to_hit;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_eos_sync  <= '0;
         r_preq_sync <= '0;
      end else begin
         r_eos_sync  <= {r_eos_sync[SYNC_STAGES-2:0], eos_i};
         r_preq_sync <= {r_preq_sync[SYNC_STAGES-2:0], preq_i};
      end
   end

   assign w_eos_s  = r_eos_sync[SYNC_STAGES-1];
   assign w_preq_s = r_preq_sync[SYNC_STAGES-1];
   assign w_drive  = (r_state == DUMMY) || (r_state == RUN) || (r_state == PROG_PEND);
   assign w_svc    = (r_state == RUN) || (r_state == PROG_PEND);

   always_ff @(posedge CLK) begin
      r_state   <= RST ? WAIT_EOS : w_state_nxt;
      r_hold    <= (RST || r_state != RST_HOLD) ? '0 : r_hold + 1'b1;
      r_strb_ok <= !RST && w_svc;
   end

`ifdef STARTUP_PACK_TIMEOUT_EN
   localparam int TW = cnt_w(PACK_TIMEOUT);
   localparam logic [TW-1:0] TO_LAST = TW'(PACK_TIMEOUT - 1);

   logic [TW-1:0] r_to;

   always_ff @(posedge CLK) begin
      if (RST || r_state != PROG_PEND)
         r_to <= '0;
      else if (!w_to_hit)
         r_to <= r_to + 1'b1;
   end

   assign w_to_hit = (r_state == PROG_PEND) && (r_to == TO_LAST);
`else
   assign w_to_hit = 1'b0;
`endif

   // losing EOS outranks every other transition; preq_s falling outranks prog_ok_i
   always_comb begin
      w_state_nxt = r_state;
      pack_o      = 1'b0;
      usr_rst_o   = 1'b1;
      usrcclkts_o = 1'b1;
      ready_o     = 1'b0;
      prog_pend_o = 1'b0;
      case (r_state)
         WAIT_EOS: w_state_nxt = w_eos_s ? RST_HOLD : WAIT_EOS;
         RST_HOLD: w_state_nxt = !w_eos_s ? WAIT_EOS : (r_hold == HOLD_LAST) ? DUMMY : RST_HOLD;
         DUMMY: begin
            usrcclkts_o = 1'b0;
            w_state_nxt = !w_eos_s ? WAIT_EOS :
                          (w_fall_nxt && w_edge_cnt == EDGE_LAST) ? RUN : DUMMY;
         end
         RUN: begin
            usr_rst_o   = 1'b0;
            usrcclkts_o = 1'b0;
            ready_o     = 1'b1;
            w_state_nxt = !w_eos_s ? WAIT_EOS : w_preq_s ? PROG_PEND : RUN;
         end
         PROG_PEND: begin
            usr_rst_o   = 1'b0;
            usrcclkts_o = 1'b0;
            ready_o     = 1'b1;
            prog_pend_o = 1'b1;
            w_state_nxt = !w_eos_s ? WAIT_EOS : !w_preq_s ? RUN :
                          (prog_ok_i || w_to_hit) ? PROG_ACK : PROG_PEND;
         end
         PROG_ACK: begin
            usr_rst_o = 1'b0;
            pack_o    = 1'b1;
         end
         default: w_state_nxt = WAIT_EOS;
      endcase
   end

   startup_cclk_gen #(
      .CCLK_HALF   (CCLK_HALF),
      .DUMMY_CCLKS (DUMMY_CCLKS)
   ) u_cclk (
      .CLK         (CLK),
      .RST         (RST),
      .i_run       (w_drive),
      .i_force_low (r_state == PROG_ACK),
      .i_en        ((r_state == DUMMY) || cclk_en_i),
      .o_cclk      (w_cclk),
      .o_rise      (w_rise),
      .o_fall      (w_fall),
      .o_fall_nxt  (w_fall_nxt),
      .o_edge_cnt  (w_edge_cnt)
   );

   // the generator lags a state change by one edge, so gate its outputs with the live state
   assign usrcclko_o  = w_cclk && w_drive;
   assign cclk_rise_o = w_rise && r_strb_ok && w_svc;
   assign cclk_fall_o = w_fall && r_strb_ok && w_svc;

endmodule

// File: tb/tb_startup_seq_ctrl.sv
// tb_startup_seq_ctrl: directed steps with randomized timing against a timeline model of the sequencer.
module tb_startup_seq_ctrl;

   localparam int SYNC = 2;
   localparam int HOLD = 16;
   localparam int HALF = 4;
   localparam int NDUM = 3;
   localparam int LAT  = SYNC + 1;
   localparam int D0   = LAT + HOLD;
   localparam int R0   = D0 + 2 * HALF * NDUM;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic eos_i = 1'b0;
   logic preq_i = 1'b0;
   logic cclk_en_i = 1'b0;
   logic prog_ok_i = 1'b0;
   logic pack_o, usrcclko_o, usrcclkts_o, usr_rst_o, ready_o, cclk_rise_o, cclk_fall_o, prog_pend_o;
   int   tests = 0;
   int   fails = 0;

   always #5 CLK = ~CLK;

   startup_seq_ctrl dut (
      .CLK         (CLK),
      .RST         (RST),
      .eos_i       (eos_i),
      .preq_i      (preq_i),
      .pack_o      (pack_o),
      .usrcclko_o  (usrcclko_o),
      .usrcclkts_o (usrcclkts_o),
      .usr_rst_o   (usr_rst_o),
      .ready_o     (ready_o),
      .cclk_en_i   (cclk_en_i),
      .cclk_rise_o (cclk_rise_o),
      .cclk_fall_o (cclk_fall_o),
      .prog_pend_o (prog_pend_o),
      .prog_ok_i   (prog_ok_i)
   );

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         @(negedge CLK);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // CCLK level n cycles after enable rose, enable held for len cycles
   function automatic bit expc(input int n, input int len);
      if (n <= 0) return 1'b0;
      if (n <= len) return ((n / HALF) % 2) == 1;
      return (((len / HALF) % 2) == 1) && (n < 2 * HALF * (len / (2 * HALF) + 1));
   endfunction

   // {usr_rst, cclkts, cclk, ready, rise, fall} n cycles after eos_i rises
   function automatic logic [5:0] pu(input int n);
      return {n < R0, n < D0, (n >= D0) && (n < R0) && (((n - D0) / HALF) % 2 == 1), n >= R0, 2'b00};
   endfunction

   task automatic run_en(input int len, output int rises);
      int  last;
      int  mr;
      bit  c;
      bit  pc;
      last  = 2 * HALF * (len / (2 * HALF) + 1) + 2;
      rises = 0;
      mr    = 0;
      pc    = 1'b0;
      cclk_en_i = 1'b1;
      for (int n = 1; n <= last; n++) begin
         step();
         c = expc(n, len);
         chk($sformatf("en%0d@%0d", len, n),
             {usrcclko_o, cclk_rise_o, cclk_fall_o, ready_o, usr_rst_o, usrcclkts_o},
             {c, c & !pc, !c & pc, 3'b100});
         rises += int'(cclk_rise_o);
         mr    += int'(c & !pc);
         pc = c;
         if (n == len) cclk_en_i = 1'b0;
      end
      chk($sformatf("en%0d_rises", len), rises, mr);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int  p, len, k, r, rises, first;
      bit  c, pc, prev;
      step(3);
      chk("reset", {pack_o, usrcclko_o, usrcclkts_o, usr_rst_o, ready_o, cclk_rise_o, cclk_fall_o, prog_pend_o}, 8'b0011_0000);
      RST = 1'b0;
      step($urandom_range(1, 20));
      chk("wait_eos", {usr_rst_o, usrcclkts_o, ready_o}, 3'b110);

      eos_i = 1'b1;
      rises = 0;
      prev  = 1'b0;
      for (int n = 1; n <= R0 + 4; n++) begin
         step();
         chk($sformatf("pu@%0d", n), {usr_rst_o, usrcclkts_o, usrcclko_o, ready_o, cclk_rise_o, cclk_fall_o}, pu(n));
         rises += int'(usrcclko_o && !prev);
         prev = usrcclko_o;
      end
      chk("dummy_rises", rises, NDUM);

      run_en(38, r);
      chk("spec_rises", r, 5);
      run_en($urandom_range(9, 45), r);
      run_en($urandom_range(9, 45), r);

      p   = $urandom_range(5, 15);
      len = $urandom_range(10, 30);
      preq_i    = 1'b1;
      cclk_en_i = 1'b1;
      pc = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         step();
         c = expc(n, len);
         chk($sformatf("preq%0d@%0d", p, n),
             {usrcclko_o, cclk_rise_o, cclk_fall_o, prog_pend_o, ready_o, pack_o},
             {c, c & !pc, !c & pc, (n >= LAT) && (n < p + LAT), 2'b10});
         pc = c;
         if (n == p) preq_i = 1'b0;
         if (n == len) cclk_en_i = 1'b0;
      end

      p = $urandom_range(4, 8);
      preq_i = 1'b1;
      for (int n = 1; n <= p + LAT + 3; n++) begin
         step();
         if (n == p) preq_i = 1'b0;
         if (n == p + LAT - 1) begin
            chk("pend_before_race", prog_pend_o, 1);
            prog_ok_i = 1'b1;
         end
         if (n == p + LAT) begin
            chk("race_preq_wins", {prog_pend_o, pack_o, ready_o}, 3'b001);
            prog_ok_i = 1'b0;
         end
      end
      chk("race_after", {pack_o, ready_o, prog_pend_o}, 3'b010);

      preq_i    = 1'b1;
      cclk_en_i = 1'b1;
      step(LAT - 1);
      chk("pend_early", prog_pend_o, 0);
      step();
      chk("pend_latency", prog_pend_o, 1);
      step($urandom_range(0, 10));
      chk("pend_hold", {prog_pend_o, pack_o, ready_o, usrcclkts_o}, 4'b1010);
      prog_ok_i = 1'b1;
      step();
      prog_ok_i = 1'b0;
      chk("ack", {pack_o, ready_o, usrcclkts_o, usrcclko_o, prog_pend_o, cclk_rise_o, cclk_fall_o}, 7'b1010000);
      eos_i  = 1'b0;
      preq_i = 1'b0;
      step($urandom_range(5, 20));
      chk("ack_sticky", {pack_o, ready_o, usrcclkts_o, usrcclko_o, prog_pend_o, cclk_rise_o, cclk_fall_o}, 7'b1010000);

      RST = 1'b1;
      step();
      chk("rst_in_ack", {pack_o, usrcclko_o, usrcclkts_o, usr_rst_o, ready_o, cclk_rise_o, cclk_fall_o, prog_pend_o}, 8'b0011_0000);
      RST = 1'b0;
      cclk_en_i = 1'b0;
      step(4);
      chk("post_rst", {pack_o, usrcclko_o, usrcclkts_o, usr_rst_o, ready_o, cclk_rise_o, cclk_fall_o, prog_pend_o}, 8'b0011_0000);

      k = $urandom_range(D0, R0 - LAT);
      eos_i = 1'b1;
      for (int n = 1; n <= k + LAT + 3; n++) begin
         step();
         chk($sformatf("eosdrop%0d@%0d", k, n), {usr_rst_o, usrcclkts_o, usrcclko_o, ready_o, cclk_rise_o, cclk_fall_o},
             (n < k + LAT) ? pu(n) : 6'b110000);
         if (n == k) eos_i = 1'b0;
      end

      eos_i = 1'b1;
      step(R0 + 2);
      chk("reboot_ready", {ready_o, usr_rst_o}, 2'b10);
      preq_i = 1'b1;
      first  = -1;
      for (int n = 1; n <= 5000; n++) begin
         step();
         if (n == LAT) chk("timeout_pend", prog_pend_o, 1);
         if (first < 0 && pack_o) first = n;
      end
`ifdef STARTUP_PACK_TIMEOUT_EN
      chk("timeout_ack", first, LAT + 1024);
`else
      chk("no_timeout", first, -1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
